// File: rtl/fwrisc_csr_pkg.sv
// Shared definitions for the register-file write arbiter.
//
// Contents:
//   CSR_MEPC / CSR_MCAUSE / CSR_MTVAL : register-file addresses of the trap
//                                       CSRs inside the CSR window
//   rf_wr_state_e                     : arbiter FSM state encoding
//
// Configuration macro: FWRISC_TRAP_MTVAL_EN adds the TRAP_TVAL state
// (3-beat trap entry). Without it a trap entry is 2 beats.
package fwrisc_csr_pkg;

  localparam logic [5:0] CSR_MEPC   = 6'h31;
  localparam logic [5:0] CSR_MCAUSE = 6'h32;
  localparam logic [5:0] CSR_MTVAL  = 6'h33;

  typedef enum logic [1:0] {
    IDLE,
    TRAP_EPC,
    TRAP_CAUSE
`ifdef FWRISC_TRAP_MTVAL_EN
    , TRAP_TVAL
`endif
  } rf_wr_state_e;

endpackage

// File: rtl/fwrisc_rf_wr_arb.sv
// Register-file write arbiter.
//
// Merges three write sources onto the single register-file write port:
// trap entry (highest priority), CSR-instruction writes, then execute
// writeback. A trap entry is a short sequence of CSR writes (MEPC, MCAUSE
// and optionally MTVAL) during which the other sources are held off.
//
// Ports:
//   clock, reset                        : rising-edge clock, sync active-high reset
//   wb_req/wb_waddr/wb_wdata -> wb_ack  : execute writeback request / accept pulse
//   csr_req/csr_waddr/csr_wdata->csr_ack: CSR-instruction write request / accept
//   trap_req/trap_epc/trap_cause/trap_tval -> trap_ack : trap entry request
//   trap_busy                           : trap write sequence in progress
//   rf_we/rf_waddr/rf_wdata             : registered register-file write port
//
// Configuration macro: FWRISC_TRAP_MTVAL_EN enables the third trap beat
// writing MTVAL; otherwise trap_tval is ignored.
module fwrisc_rf_wr_arb
  import fwrisc_csr_pkg::*;
#(
  parameter int RF_AW    = 6,
  parameter int MCAUSE_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wb_req,
  input  logic [RF_AW-1:0]    wb_waddr,
  input  logic [31:0]         wb_wdata,
  output logic                wb_ack,
  input  logic                csr_req,
  input  logic [RF_AW-1:0]    csr_waddr,
  input  logic [31:0]         csr_wdata,
  output logic                csr_ack,
  input  logic                trap_req,
  input  logic [31:0]         trap_epc,
  input  logic [MCAUSE_W-1:0] trap_cause,
  input  logic [31:0]         trap_tval,
  output logic                trap_ack,
  output logic                trap_busy,
  output logic                rf_we,
  output logic [RF_AW-1:0]    rf_waddr,
  output logic [31:0]         rf_wdata
);

  rf_wr_state_e state;
  logic [31:0]  epc_q;
  logic [31:0]  cause_q;
  logic         grant_trap;
  logic         grant_csr;
  logic         grant_wb;

`ifdef FWRISC_TRAP_MTVAL_EN
  logic [31:0]  tval_q;
`else
  logic         unused_tval;
  assign unused_tval = ^trap_tval;
`endif

  // Fixed-priority grant. Only IDLE can grant, and nothing is granted while
  // reset is held so the acks stay low during reset.
  always_comb begin
    grant_trap = 1'b0;
    grant_csr  = 1'b0;
    grant_wb   = 1'b0;
    if (!reset && state == IDLE) begin
      if (trap_req)     grant_trap = 1'b1;
      else if (csr_req) grant_csr  = 1'b1;
      else if (wb_req)  grant_wb   = 1'b1;
    end
  end

  assign trap_ack = grant_trap;
  assign csr_ack  = grant_csr;
  assign wb_ack   = grant_wb;

  // FSM and registered write port. Each granted write or trap beat lands on
  // the write port one cycle later; rf_we defaults low every cycle. Writes
  // to x0 are accepted but never raise rf_we.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      trap_busy <= 1'b0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      epc_q     <= '0;
      cause_q   <= '0;
`ifdef FWRISC_TRAP_MTVAL_EN
      tval_q    <= '0;
`endif
    end else begin
      rf_we <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_trap) begin
            epc_q     <= trap_epc;
            cause_q   <= 32'(trap_cause);
`ifdef FWRISC_TRAP_MTVAL_EN
            tval_q    <= trap_tval;
`endif
            state     <= TRAP_EPC;
            trap_busy <= 1'b1;
          end else if (grant_csr) begin
            rf_we    <= (csr_waddr != '0);
            rf_waddr <= csr_waddr;
            rf_wdata <= csr_wdata;
          end else if (grant_wb) begin
            rf_we    <= (wb_waddr != '0);
            rf_waddr <= wb_waddr;
            rf_wdata <= wb_wdata;
          end
        end
        TRAP_EPC: begin
          rf_we    <= 1'b1;
          rf_waddr <= RF_AW'(CSR_MEPC);
          rf_wdata <= epc_q;
          state    <= TRAP_CAUSE;
        end
        TRAP_CAUSE: begin
          rf_we    <= 1'b1;
          rf_waddr <= RF_AW'(CSR_MCAUSE);
          rf_wdata <= cause_q;
`ifdef FWRISC_TRAP_MTVAL_EN
          state    <= TRAP_TVAL;
`else
          state     <= IDLE;
          trap_busy <= 1'b0;
`endif
        end
`ifdef FWRISC_TRAP_MTVAL_EN
        TRAP_TVAL: begin
          rf_we     <= 1'b1;
          rf_waddr  <= RF_AW'(CSR_MTVAL);
          rf_wdata  <= tval_q;
          state     <= IDLE;
          trap_busy <= 1'b0;
        end
`endif
        default: begin
          state     <= IDLE;
          trap_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fwrisc_rf_wr_arb.sv
// Self-checking bench for fwrisc_rf_wr_arb.
//
// The reference model tracks a trap as a queue of pending CSR writes and
// predicts acks and the next register-file write each cycle. Directed
// scenarios run first, followed by randomized request traffic with
// occasional resets. Honours FWRISC_TRAP_MTVAL_EN like the design.
module tb_fwrisc_rf_wr_arb;

  localparam logic [5:0] A_MEPC   = 6'h31;
  localparam logic [5:0] A_MCAUSE = 6'h32;
  localparam logic [5:0] A_MTVAL  = 6'h33;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wb_req = 1'b0;
  logic [5:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic        wb_ack;
  logic        csr_req = 1'b0;
  logic [5:0]  csr_waddr = '0;
  logic [31:0] csr_wdata = '0;
  logic        csr_ack;
  logic        trap_req = 1'b0;
  logic [31:0] trap_epc = '0;
  logic [31:0] trap_cause = '0;
  logic [31:0] trap_tval = '0;
  logic        trap_ack;
  logic        trap_busy;
  logic        rf_we;
  logic [5:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_checks = 0;
  int n_fail   = 0;
  wr_t beat_q[$];

  fwrisc_rf_wr_arb #(.RF_AW(6), .MCAUSE_W(32)) dut (
    .clock(clock), .reset(reset),
    .wb_req(wb_req), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_ack(wb_ack),
    .csr_req(csr_req), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_ack(csr_ack),
    .trap_req(trap_req), .trap_epc(trap_epc), .trap_cause(trap_cause),
    .trap_tval(trap_tval), .trap_ack(trap_ack), .trap_busy(trap_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input bit t, input logic [31:0] epc, input logic [31:0] cause,
                                input logic [31:0] tval, input bit c, input logic [5:0] caddr,
                                input logic [31:0] cdata, input bit w, input logic [5:0] waddr,
                                input logic [31:0] wdata);
    trap_req = t;  trap_epc = epc;    trap_cause = cause; trap_tval = tval;
    csr_req  = c;  csr_waddr = caddr; csr_wdata = cdata;
    wb_req   = w;  wb_waddr = waddr;  wb_wdata = wdata;
  endtask

  // New requests appear only on idle requesters; pending ones are held.
  task automatic drive_random();
    if (!trap_req && $urandom_range(0, 9) == 0) begin
      trap_req = 1'b1; trap_epc = $urandom; trap_cause = $urandom; trap_tval = $urandom;
    end
    if (!csr_req && $urandom_range(0, 3) == 0) begin
      csr_req = 1'b1;
      csr_waddr = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom);
      csr_wdata = $urandom;
    end
    if (!wb_req && $urandom_range(0, 1) == 0) begin
      wb_req = 1'b1;
      wb_waddr = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom);
      wb_wdata = $urandom;
    end
  endtask

  // One clock cycle: predict and check acks/busy, then the registered write.
  task automatic step(input bit do_reset);
    bit          busy, e_trap, e_csr, e_wb, n_we, chk_ad;
    logic [5:0]  n_addr;
    logic [31:0] n_data;
    wr_t         w;
    reset = do_reset;
    #1;
    busy   = (beat_q.size() != 0);
    e_trap = !do_reset && !busy && trap_req;
    e_csr  = !do_reset && !busy && csr_req && !trap_req;
    e_wb   = !do_reset && !busy && wb_req && !csr_req && !trap_req;
    check_output("trap_busy", {31'd0, trap_busy}, {31'd0, busy});
    check_output("trap_ack", {31'd0, trap_ack}, {31'd0, e_trap});
    check_output("csr_ack", {31'd0, csr_ack}, {31'd0, e_csr});
    check_output("wb_ack", {31'd0, wb_ack}, {31'd0, e_wb});
    n_we = 1'b0; chk_ad = 1'b0; n_addr = '0; n_data = '0;
    if (do_reset) begin
      beat_q.delete();
      chk_ad = 1'b1;
    end else if (busy) begin
      w = beat_q.pop_front();
      n_we = 1'b1; n_addr = w.addr; n_data = w.data; chk_ad = 1'b1;
    end else if (e_trap) begin
      beat_q.push_back('{A_MEPC, trap_epc});
      beat_q.push_back('{A_MCAUSE, trap_cause});
`ifdef FWRISC_TRAP_MTVAL_EN
      beat_q.push_back('{A_MTVAL, trap_tval});
`endif
    end else if (e_csr) begin
      n_we = (csr_waddr != 6'd0); n_addr = csr_waddr; n_data = csr_wdata; chk_ad = n_we;
    end else if (e_wb) begin
      n_we = (wb_waddr != 6'd0); n_addr = wb_waddr; n_data = wb_wdata; chk_ad = n_we;
    end
    @(posedge clock);
    #1;
    check_output("rf_we", {31'd0, rf_we}, {31'd0, n_we});
    if (chk_ad) begin
      check_output("rf_waddr", {26'd0, rf_waddr}, {26'd0, n_addr});
      check_output("rf_wdata", rf_wdata, n_data);
    end
    if (e_trap) trap_req = 1'b0;
    if (e_csr)  csr_req  = 1'b0;
    if (e_wb)   wb_req   = 1'b0;
    @(negedge clock);
  endtask

  task automatic drain();
    for (int i = 0; i < 5; i++) step(1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_output("reset_busy", {31'd0, trap_busy}, 32'd0);
    check_output("reset_we", {31'd0, rf_we}, 32'd0);
    check_output("reset_waddr", {26'd0, rf_waddr}, 32'd0);
    check_output("reset_wdata", rf_wdata, 32'd0);
    check_output("reset_acks", {29'd0, trap_ack, csr_ack, wb_ack}, 32'd0);

    // Single writeback
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 6'd5, 32'hDEADBEEF);
    step(1'b0);
    check_output("wb5_we", {31'd0, rf_we}, 32'd1);
    check_output("wb5_addr", {26'd0, rf_waddr}, 32'd5);
    check_output("wb5_data", rf_wdata, 32'hDEADBEEF);
    drain();

    // CSR beats writeback, writeback follows
    apply_stimulus(0, 0, 0, 0, 1, 6'd9, 32'h11111111, 1, 6'd7, 32'h22222222);
    step(1'b0);
    check_output("csr_first_addr", {26'd0, rf_waddr}, 32'd9);
    step(1'b0);
    check_output("wb_second_addr", {26'd0, rf_waddr}, 32'd7);
    check_output("wb_second_data", rf_wdata, 32'h22222222);
    drain();

    // Trap with writeback pending
    apply_stimulus(1, 32'h100, 32'hB, 32'h80000004, 0, 0, 0, 1, 6'd3, 32'h33333333);
    step(1'b0);
    step(1'b0);
    check_output("trap_mepc_addr", {26'd0, rf_waddr}, 32'h31);
    check_output("trap_mepc_data", rf_wdata, 32'h100);
    step(1'b0);
    check_output("trap_mcause_addr", {26'd0, rf_waddr}, 32'h32);
    check_output("trap_mcause_data", rf_wdata, 32'hB);
`ifdef FWRISC_TRAP_MTVAL_EN
    step(1'b0);
    check_output("trap_mtval_addr", {26'd0, rf_waddr}, 32'h33);
    check_output("trap_mtval_data", rf_wdata, 32'h80000004);
`endif
    check_output("trap_wb_still_pending", {31'd0, wb_req}, 32'd1);
    drain();
    check_output("trap_wb_done", {31'd0, wb_req}, 32'd0);

    // Write to x0 is acked but discarded
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 6'd0, 32'h1234);
    step(1'b0);
    check_output("x0_we", {31'd0, rf_we}, 32'd0);
    drain();

    // Reset while in TRAP_EPC abandons the trap
    apply_stimulus(1, 32'h200, 32'h7, 32'h5, 0, 0, 0, 0, 0, 0);
    step(1'b0);
    step(1'b1);
    check_output("rst_trap_we", {31'd0, rf_we}, 32'd0);
    step(1'b0);
    check_output("rst_trap_no_mcause", {31'd0, rf_we}, 32'd0);
    drain();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive_random();
      step($urandom_range(0, 49) == 0);
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fwrisc_rf_wr_arb.md
FWRISC_RF_WR_ARB -- requirements
Module: fwrisc_rf_wr_arb

Interface
REQ-001 SHALL have parameter RF_AW, default 6, register-file address width (32 GPRs + CSR window).
REQ-002 SHALL have parameter MCAUSE_W, default 32, width of trap cause value.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports wb_req/wb_waddr/wb_wdata  input  1/RF_AW/32  exec writeback request.
REQ-006 SHALL have port wb_ack  output  1  writeback accepted this cycle.
REQ-007 SHALL have ports csr_req/csr_waddr/csr_wdata  input  1/RF_AW/32  CSR-instruction write request.
REQ-008 SHALL have port csr_ack  output  1  CSR write accepted this cycle.
REQ-009 SHALL have ports trap_req/trap_epc/trap_cause/trap_tval  input  1/32/MCAUSE_W/32  trap entry request.
REQ-010 SHALL have ports trap_ack/trap_busy  output  1/1  trap accepted / trap sequence in progress.
REQ-011 SHALL have ports rf_we/rf_waddr/rf_wdata  output  1/RF_AW/32  registered register-file write port.

Function
REQ-012 SHALL implement FSM states IDLE, TRAP_EPC, TRAP_CAUSE (plus TRAP_TVAL, see REQ-026).
REQ-013 SHALL in IDLE grant at most one requester per cycle, fixed priority trap > csr > wb.
REQ-014 SHALL assert the ack of the granted requester combinationally in the grant cycle; ack is a one-cycle pulse.
REQ-015 SHALL drive rf_we/rf_waddr/rf_wdata for a granted write in the cycle after grant (latency 1).
REQ-016 SHALL accept requests held high until ack; non-granted requests remain pending with no side effects.
REQ-017 SHALL ack wb/csr writes to address 0 but keep rf_we low (x0 discard).
REQ-018 SHALL on trap grant capture epc/cause/tval, pulse trap_ack, and move IDLE -> TRAP_EPC.
REQ-019 SHALL in TRAP_EPC write CSR_MEPC <= epc, then move to TRAP_CAUSE.
REQ-020 SHALL in TRAP_CAUSE write CSR_MCAUSE <= cause (zero-extended to 32), then return to IDLE (or TRAP_TVAL if enabled).
REQ-021 SHALL hold trap_busy high in every non-IDLE state and block wb/csr grants there.
REQ-022 SHALL drive rf_we low in any cycle with no granted write from the previous cycle or trap beat.
REQ-023 SHALL sample new trap_req only in IDLE; trap_req during trap_busy waits.

Reset
REQ-024 SHALL on reset force IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, all acks 0, trap_busy=0.
REQ-025 SHALL on reset mid-trap abandon remaining beats; no rf_we in the cycle after reset.

Configuration
REQ-026 SHALL with macro FWRISC_TRAP_MTVAL_EN defined add state TRAP_TVAL after TRAP_CAUSE writing CSR_MTVAL <= tval (3-beat trap); without it, trap is 2 beats, trap_tval is ignored, TRAP_TVAL absent.

Structure
REQ-027 SHALL take CSR_MEPC=6'h31, CSR_MCAUSE=6'h32, CSR_MTVAL=6'h33 and the FSM state enum from shared package fwrisc_csr_pkg.
REQ-028 SHALL be a single module with no sub-modules; priority grant logic kept in one combinational block.

Verification
REQ-029 wb_req, waddr=5, wdata=0xDEADBEEF -> wb_ack same cycle; next cycle rf_we=1, waddr=5, wdata=0xDEADBEEF.
REQ-030 csr_req and wb_req same cycle -> csr_ack first, wb_ack following cycle, two consecutive rf writes csr then wb.
REQ-031 trap_req epc=0x100, cause=0xB with wb_req pending -> trap_ack; rf writes 0x31<=0x100 then 0x32<=0xB; trap_busy 2 cycles; wb_ack only after return to IDLE.
REQ-032 wb_req waddr=0, wdata=0x1234 -> wb_ack=1, rf_we stays 0.
REQ-033 reset asserted in TRAP_EPC -> IDLE, rf_we=0 next cycle, no MCAUSE write.
REQ-034 FWRISC_TRAP_MTVAL_EN defined, trap tval=0x80000004 -> third write 0x33<=0x80000004, trap_busy 3 cycles.
